// File: rtl/mode4_sum_accum_pkg.sv
// Shared softmax package: FSM state encoding, fp16 zero and exponent field
// geometry used by the mode-4 row accumulator.
package mode4_sum_accum_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ACCUM = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    localparam int          FP16_W    = 16;
    localparam logic [15:0] FP16_ZERO = 16'h0000;
    localparam int          EXP_LSB   = 10;
    localparam int          EXP_W     = 5;

    // All-ones exponent marks inf or NaN.
    function automatic logic fp16_is_inf_nan(input logic [FP16_W-1:0] v);
        return &v[EXP_LSB +: EXP_W];
    endfunction

endpackage

// File: rtl/mode4_sum_accum_if.sv
// Bundle of row-control, adder-tree and result handshake signals for
// mode4_sum_accum; master drives the block, slave is the block itself.
interface mode4_sum_accum_if #(
    parameter int DATAWIDTH = 16,
    parameter int CNTWIDTH  = 8
);
    logic                 start;
    logic [CNTWIDTH-1:0]  row_beats;
    logic                 tree_valid;
    logic [DATAWIDTH-1:0] tree_sum;
    logic                 tree_ready;
    logic [DATAWIDTH-1:0] acc_feedback;
    logic                 sum_valid;
    logic                 sum_ready;
    logic [DATAWIDTH-1:0] sum_out;
    logic                 busy;

    modport master (
        output start, row_beats, tree_valid, tree_sum, sum_ready,
        input  tree_ready, acc_feedback, sum_valid, sum_out, busy
    );

    modport slave (
        input  start, row_beats, tree_valid, tree_sum, sum_ready,
        output tree_ready, acc_feedback, sum_valid, sum_out, busy
    );
endinterface

// File: rtl/mode4_sum_accum.sv
// Row accumulator for the mode-4 fp16 adder tree: holds the running sum fed
// back to the tree and emits the final row sum. Optional MODE4_ACC_OVF_DETECT_EN.
module mode4_sum_accum
    import mode4_sum_accum_pkg::*;
#(
    parameter int DATAWIDTH = 16,
    parameter int CNTWIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    mode4_sum_accum_if.slave       bus
`ifdef MODE4_ACC_OVF_DETECT_EN
    ,
    output logic                   ovf
`endif
);

    state_t               state_q, state_d;
    logic [DATAWIDTH-1:0] acc_q, acc_d;
    logic [CNTWIDTH-1:0]  cnt_q, cnt_d;
    logic [CNTWIDTH-1:0]  beats_q, beats_d;
    logic                 start_row;
    logic                 accept;

    assign start_row = (state_q == ST_IDLE) && bus.start;
    assign accept    = (state_q == ST_ACCUM) && bus.tree_valid;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        beats_d = beats_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    beats_d = bus.row_beats;
                    acc_d   = DATAWIDTH'(FP16_ZERO);
                    cnt_d   = '0;
                    state_d = (bus.row_beats == '0) ? ST_DONE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                // The tree already folded acc_feedback in; just capture its result.
                if (bus.tree_valid) begin
                    acc_d = bus.tree_sum;
                    cnt_d = cnt_q + CNTWIDTH'(1);
                    if (cnt_q == beats_q - CNTWIDTH'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (bus.sum_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acc_q   <= DATAWIDTH'(FP16_ZERO);
            cnt_q   <= '0;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            beats_q <= beats_d;
        end
    end

`ifdef MODE4_ACC_OVF_DETECT_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (start_row) begin
            ovf_d = 1'b0;
        end else if (accept && fp16_is_inf_nan(FP16_W'(bus.tree_sum))) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign bus.tree_ready   = (state_q == ST_ACCUM);
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.sum_valid    = (state_q == ST_DONE);
    assign bus.acc_feedback = acc_q;
    // Outside DONE the result bus is parked at zero so no partial sum is visible.
    assign bus.sum_out      = (state_q == ST_DONE) ? acc_q : DATAWIDTH'(FP16_ZERO);

endmodule

// File: tb/tb_mode4_sum_accum.sv
// Scoreboard bench for mode4_sum_accum: directed rows push expected sums,
// a negedge monitor pops them on each sum_valid/sum_ready handshake.
module tb_mode4_sum_accum;

    typedef struct {
        logic [15:0] sum;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

`ifdef MODE4_ACC_OVF_DETECT_EN
    logic ovf;
`endif

    mode4_sum_accum_if #(.DATAWIDTH(16), .CNTWIDTH(8)) bus ();

    mode4_sum_accum #(.DATAWIDTH(16), .CNTWIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef MODE4_ACC_OVF_DETECT_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [15:0] s, input logic o);
        exp_t e;
        e.sum = s;
        e.ovf = o;
        sb_q.push_back(e);
    endtask

    // Monitor: every handshake must match the oldest expected row result.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.sum_valid === 1'b1 && bus.sum_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_sum got %h expected no result", bus.sum_out);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sum_out", 32'(bus.sum_out), 32'(e.sum));
`ifdef MODE4_ACC_OVF_DETECT_EN
                check("ovf_at_valid", 32'(ovf), 32'(e.ovf));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.row_beats  = 8'd0;
        bus.tree_valid = 1'b0;
        bus.tree_sum   = 16'h0000;
        bus.sum_ready  = 1'b1;
        repeat (3) tick();

        check("rst_busy",       32'(bus.busy),         32'h0);
        check("rst_tree_ready", 32'(bus.tree_ready),   32'h0);
        check("rst_sum_valid",  32'(bus.sum_valid),    32'h0);
        check("rst_sum_out",    32'(bus.sum_out),      32'h0);
        check("rst_feedback",   32'(bus.acc_feedback), 32'h0);
        reset = 1'b0;

        // Row of 3 back-to-back beats, start on the first edge after reset.
        bus.start = 1'b1; bus.row_beats = 8'd3;
        push_exp(16'h4400, 1'b0);
        tick();
        bus.start = 1'b0;
        check("r1_fb0",         32'(bus.acc_feedback), 32'h0000);
        check("r1_tree_ready",  32'(bus.tree_ready),   32'h1);
        check("r1_busy",        32'(bus.busy),         32'h1);
        bus.tree_valid = 1'b1; bus.tree_sum = 16'h3C00;
        tick();
        check("r1_fb1",         32'(bus.acc_feedback), 32'h3C00);
        check("r1_valid_early", 32'(bus.sum_valid),    32'h0);
        bus.tree_sum = 16'h4000;
        tick();
        check("r1_fb2",         32'(bus.acc_feedback), 32'h4000);
        bus.tree_sum = 16'h4400;
        tick();
        bus.tree_valid = 1'b0;
        check("r1_fb3",         32'(bus.acc_feedback), 32'h4400);
        check("r1_sum_valid",   32'(bus.sum_valid),    32'h1);
        tick();
        check("r1_idle_valid",  32'(bus.sum_valid),    32'h0);
        check("r1_idle_busy",   32'(bus.busy),         32'h0);

        // Empty row goes straight to DONE with a zero sum.
        bus.start = 1'b1; bus.row_beats = 8'd0;
        push_exp(16'h0000, 1'b0);
        tick();
        bus.start = 1'b0;
        check("r0_sum_valid",   32'(bus.sum_valid),    32'h1);
        check("r0_sum_out",     32'(bus.sum_out),      32'h0000);
        tick();
        check("r0_idle",        32'(bus.busy),         32'h0);

        // Two beats with a 3-cycle gap, consumer stalls 4 cycles in DONE.
        bus.sum_ready = 1'b0;
        bus.start = 1'b1; bus.row_beats = 8'd2;
        push_exp(16'h4200, 1'b0);
        tick();
        bus.start = 1'b0;
        bus.tree_valid = 1'b1; bus.tree_sum = 16'h3C00;
        tick();
        bus.tree_valid = 1'b0; bus.tree_sum = 16'h7BFF;
        repeat (3) tick();
        check("r2_gap_fb",      32'(bus.acc_feedback), 32'h3C00);
        check("r2_gap_valid",   32'(bus.sum_valid),    32'h0);
        bus.tree_valid = 1'b1; bus.tree_sum = 16'h4200;
        tick();
        bus.tree_sum = 16'h1234;
        for (int i = 0; i < 4; i++) begin
            check("r2_hold_valid", 32'(bus.sum_valid),  32'h1);
            check("r2_hold_sum",   32'(bus.sum_out),    32'h4200);
            check("r2_hold_tready", 32'(bus.tree_ready), 32'h0);
            tick();
        end
        bus.tree_valid = 1'b0;
        bus.sum_ready = 1'b1;
        tick();
        check("r2_idle_busy",   32'(bus.busy),         32'h0);
        check("r2_idle_valid",  32'(bus.sum_valid),    32'h0);

        // tree_valid is ignored in IDLE.
        bus.tree_valid = 1'b1; bus.tree_sum = 16'h1111;
        tick();
        bus.tree_valid = 1'b0;
        check("idle_tv_fb",     32'(bus.acc_feedback), 32'h4200);
        check("idle_tv_busy",   32'(bus.busy),         32'h0);

        // Reset mid-row after 1 of 4 beats.
        bus.start = 1'b1; bus.row_beats = 8'd4;
        tick();
        bus.start = 1'b0;
        bus.tree_valid = 1'b1; bus.tree_sum = 16'h3C00;
        tick();
        bus.tree_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("mid_rst_busy",   32'(bus.busy),         32'h0);
        check("mid_rst_tready", 32'(bus.tree_ready),   32'h0);
        check("mid_rst_valid",  32'(bus.sum_valid),    32'h0);
        check("mid_rst_sum",    32'(bus.sum_out),      32'h0);
        check("mid_rst_fb",     32'(bus.acc_feedback), 32'h0);
        tick();
        reset = 1'b0;
        bus.start = 1'b1; bus.row_beats = 8'd1;
        push_exp(16'h3800, 1'b0);
        tick();
        bus.start = 1'b0;
        bus.tree_valid = 1'b1; bus.tree_sum = 16'h3800;
        tick();
        bus.tree_valid = 1'b0;
        check("r4_sum_valid",   32'(bus.sum_valid),    32'h1);
        tick();

        // start pulses during ACCUM and DONE are ignored.
        bus.start = 1'b1; bus.row_beats = 8'd2;
        push_exp(16'h4000, 1'b0);
        tick();
        bus.start = 1'b0;
        bus.tree_valid = 1'b1; bus.tree_sum = 16'h3C00;
        tick();
        bus.tree_valid = 1'b0;
        bus.start = 1'b1; bus.row_beats = 8'd0;
        tick();
        bus.start = 1'b0;
        check("acc_start_fb",   32'(bus.acc_feedback), 32'h3C00);
        check("acc_start_valid", 32'(bus.sum_valid),   32'h0);
        check("acc_start_busy", 32'(bus.busy),         32'h1);
        bus.tree_valid = 1'b1; bus.tree_sum = 16'h4000;
        bus.sum_ready = 1'b0;
        tick();
        bus.tree_valid = 1'b0;
        bus.start = 1'b1; bus.row_beats = 8'd5;
        tick();
        bus.start = 1'b0;
        check("done_start_valid", 32'(bus.sum_valid),  32'h1);
        check("done_start_sum",   32'(bus.sum_out),    32'h4000);
        bus.sum_ready = 1'b1;
        tick();
        check("done_start_idle",  32'(bus.busy),       32'h0);

`ifdef MODE4_ACC_OVF_DETECT_EN
        // Infinite beat sets sticky ovf; next start clears it.
        bus.start = 1'b1; bus.row_beats = 8'd2;
        push_exp(16'h3C00, 1'b1);
        tick();
        bus.start = 1'b0;
        check("ovf_clear0",     32'(ovf),              32'h0);
        bus.tree_valid = 1'b1; bus.tree_sum = 16'h7C00;
        tick();
        check("ovf_set",        32'(ovf),              32'h1);
        bus.tree_sum = 16'h3C00;
        tick();
        bus.tree_valid = 1'b0;
        tick();
        check("ovf_sticky_idle", 32'(ovf),             32'h1);
        bus.start = 1'b1; bus.row_beats = 8'd1;
        push_exp(16'h3C00, 1'b0);
        tick();
        bus.start = 1'b0;
        check("ovf_cleared",    32'(ovf),              32'h0);
        bus.tree_valid = 1'b1; bus.tree_sum = 16'h3C00;
        tick();
        bus.tree_valid = 1'b0;
        tick();
`endif

        repeat (3) tick();
        check("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
